// File: rtl/tx_data_buffer.sv
// ---------------------------------------------------------------------------
// tx_data_buffer
// Byte FIFO between the AHB-side register stage and the USB TX stage.
// First-word fall-through: the oldest byte is presented combinationally on
// tx_packet_data with no added latency, and reads as 8'h00 while empty.
//
// Parameters
//   DEPTH              byte capacity, power of two in 4..128
//
// Ports
//   clk                single clock, all state updates on its rising edge
//   rst                synchronous active-high reset
//   store_tx_data      write strobe, one byte per asserted cycle
//   tx_data[7:0]       byte written when store_tx_data=1
//   clear              flush request, priority over store and pop
//   get_tx_packet_data pop strobe, one byte per asserted cycle
//   tx_packet_data     oldest stored byte (8'h00 when empty)
//   buffer_occupancy   stored byte count, zero-extended to 8 bits
//   full, empty        occupancy==DEPTH / occupancy==0
//   overflow_err       sticky: write attempted while full with no pop
//   underflow_err      sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module tx_data_buffer #(
    parameter int unsigned DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       clear,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    output logic [7:0] buffer_occupancy,
    output logic       full,
    output logic       empty,
    output logic       overflow_err,
    output logic       underflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic          pop_ok_c;
    logic          wr_ok_c;

    // Status flags come straight from the registered counter.
    assign full             = (count == CW'(DEPTH));
    assign empty            = (count == CW'(0));
    assign buffer_occupancy = 8'(count);

    // A pop frees a slot in the same cycle, so a write while full is
    // still accepted when paired with an accepted pop.
    assign pop_ok_c = get_tx_packet_data && !empty;
    assign wr_ok_c  = store_tx_data && (!full || pop_ok_c);

    // Fall-through read port.
    assign tx_packet_data = empty ? 8'h00 : mem[rptr];

    // Pointers, occupancy counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok_c) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_ok_c, pop_ok_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (store_tx_data && !wr_ok_c) begin
                overflow_err <= 1'b1;
            end
            if (get_tx_packet_data && !pop_ok_c) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Storage array; contents survive reset and clear, only pointers move.
    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_ok_c) begin
            mem[wptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_tx_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_data_buffer
// Directed self-checking bench for tx_data_buffer (DEPTH=64). Inputs are
// driven 1 ns after each rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_tx_data_buffer;

    logic       clk;
    logic       rst;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       clear;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [7:0] buffer_occupancy;
    logic       full;
    logic       empty;
    logic       overflow_err;
    logic       underflow_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] seq [64];

    tx_data_buffer #(.DEPTH(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .clear              (clear),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .full               (full),
        .empty              (empty),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        store_tx_data = 1'b1;
        tx_data       = b;
        tick();
        store_tx_data = 1'b0;
    endtask

    // Check the head byte, then pop it.
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk8(tag, tx_packet_data, exp);
        get_tx_packet_data = 1'b1;
        tick();
        get_tx_packet_data = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk8({tag, "_occ"},   buffer_occupancy, 8'd0);
        chk1({tag, "_empty"}, empty,            1'b1);
        chk1({tag, "_full"},  full,             1'b0);
        chk1({tag, "_ovf"},   overflow_err,     1'b0);
        chk1({tag, "_udf"},   underflow_err,    1'b0);
        chk8({tag, "_data"},  tx_packet_data,   8'h00);
    endtask

    initial begin
        rst                = 1'b1;
        store_tx_data      = 1'b0;
        tx_data            = 8'h00;
        clear              = 1'b0;
        get_tx_packet_data = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Fill order: four bytes, occupancy steps, FIFO order out.
        wr(8'h11);
        chk8("fill_occ1", buffer_occupancy, 8'd1);
        chk8("fill_head", tx_packet_data, 8'h11);
        wr(8'h22);
        chk8("fill_occ2", buffer_occupancy, 8'd2);
        wr(8'h33);
        chk8("fill_occ3", buffer_occupancy, 8'd3);
        wr(8'h44);
        chk8("fill_occ4", buffer_occupancy, 8'd4);
        pop_chk("fill_pop0", 8'h11);
        pop_chk("fill_pop1", 8'h22);
        pop_chk("fill_pop2", 8'h33);
        pop_chk("fill_pop3", 8'h44);
        chk1("fill_empty", empty, 1'b1);
        chk8("fill_data0", tx_packet_data, 8'h00);

        // Full and overflow.
        for (int i = 0; i < 64; i++) seq[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 64; i++) wr(seq[i]);
        chk1("ovf_full", full, 1'b1);
        chk8("ovf_occ64", buffer_occupancy, 8'd64);
        chk1("ovf_pre", overflow_err, 1'b0);
        wr(8'hAA);
        chk8("ovf_occ_after", buffer_occupancy, 8'd64);
        chk1("ovf_flag", overflow_err, 1'b1);
        chk8("ovf_head", tx_packet_data, 8'h01);
        for (int i = 0; i < 64; i++) pop_chk($sformatf("ovf_pop%0d", i), seq[i]);
        chk1("ovf_empty", empty, 1'b1);
        chk1("ovf_sticky", overflow_err, 1'b1);
        do_clear();
        chk1("ovf_cleared", overflow_err, 1'b0);

        // Simultaneous write+pop while full: slot recycled, no overflow.
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'hC0 ^ i);
        for (int i = 0; i < 64; i++) wr(seq[i]);
        store_tx_data      = 1'b1;
        tx_data            = 8'h55;
        get_tx_packet_data = 1'b1;
        tick();
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        chk8("sim_full_occ", buffer_occupancy, 8'd64);
        chk1("sim_full_ovf", overflow_err, 1'b0);
        chk8("sim_full_head", tx_packet_data, seq[1]);
        for (int i = 1; i < 64; i++) pop_chk($sformatf("sim_pop%0d", i), seq[i]);
        pop_chk("sim_pop_last", 8'h55);
        chk1("sim_empty", empty, 1'b1);

        // Simultaneous write+pop while empty: write only, underflow set.
        store_tx_data      = 1'b1;
        tx_data            = 8'h66;
        get_tx_packet_data = 1'b1;
        tick();
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        chk8("sim_empty_occ", buffer_occupancy, 8'd1);
        chk1("sim_empty_udf", underflow_err, 1'b1);
        chk8("sim_empty_data", tx_packet_data, 8'h66);
        pop_chk("sim_empty_pop", 8'h66);
        chk1("sim_udf_sticky", underflow_err, 1'b1);
        do_clear();

        // Wrap-around across the pointer boundary.
        for (int i = 0; i < 60; i++) wr(8'(8'h80 + i));
        chk8("wrap_occ60", buffer_occupancy, 8'd60);
        for (int i = 0; i < 60; i++) pop_chk($sformatf("wrap_a%0d", i), 8'(8'h80 + i));
        for (int i = 0; i < 10; i++) wr(8'(8'h20 + i * 7));
        chk8("wrap_occ10", buffer_occupancy, 8'd10);
        for (int i = 0; i < 10; i++) pop_chk($sformatf("wrap_b%0d", i), 8'(8'h20 + i * 7));
        chk8("wrap_occ0", buffer_occupancy, 8'd0);
        chk1("wrap_udf", underflow_err, 1'b0);

        // Clear priority over store and pop, with an error flag pending.
        get_tx_packet_data = 1'b1;
        tick();
        get_tx_packet_data = 1'b0;
        chk1("clr_udf_set", underflow_err, 1'b1);
        chk8("clr_udf_occ", buffer_occupancy, 8'd0);
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
        chk8("clr_occ5", buffer_occupancy, 8'd5);
        clear              = 1'b1;
        store_tx_data      = 1'b1;
        tx_data            = 8'hEE;
        get_tx_packet_data = 1'b1;
        tick();
        clear              = 1'b0;
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        chk_reset_state("clr");

        // Reset mid-operation overrides a concurrent write.
        for (int i = 0; i < 7; i++) wr(8'(8'hB0 + i));
        chk8("rst_occ7", buffer_occupancy, 8'd7);
        rst           = 1'b1;
        store_tx_data = 1'b1;
        tx_data       = 8'h77;
        tick();
        rst           = 1'b0;
        store_tx_data = 1'b0;
        chk_reset_state("rst_mid");
        wr(8'h9C);
        chk8("rst_wr_occ", buffer_occupancy, 8'd1);
        chk8("rst_wr_data", tx_packet_data, 8'h9C);
        pop_chk("rst_wr_pop", 8'h9C);
        chk1("rst_final_empty", empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_data_buffer.md
TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning byte capacity; it is a power of two in the range 4..128.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port store_tx_data, input, 1 bit: write strobe from the AHB-side register stage, one byte per asserted cycle.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte written when store_tx_data=1.
REQ-006 The block SHALL have port clear, input, 1 bit: flush request; it empties the buffer.
REQ-007 The block SHALL have port get_tx_packet_data, input, 1 bit: pop strobe from the USB TX stage, one byte per asserted cycle.
REQ-008 The block SHALL have port tx_packet_data, output, 8 bits: the oldest stored byte (first-word fall-through).
REQ-009 The block SHALL have port buffer_occupancy, output, 8 bits: the count of stored bytes, 0..DEPTH, zero-extended.
REQ-010 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy==DEPTH and occupancy==0 respectively.
REQ-011 The block SHALL have ports overflow_err and underflow_err, outputs, 1 bit each: sticky error flags.

Function
REQ-012 Storage SHALL be a circular array of DEPTH bytes, with write pointer wptr and read pointer rptr of log2(DEPTH) bits each, both wrapping from DEPTH-1 to 0.
REQ-013 The occupancy counter SHALL be log2(DEPTH)+1 bits wide and registered; buffer_occupancy, full and empty SHALL derive from this register only.
REQ-014 A write SHALL be accepted iff store_tx_data=1 and (!full or pop accepted the same cycle); on acceptance mem[wptr]<=tx_data and wptr increments.
REQ-015 A pop SHALL be accepted iff get_tx_packet_data=1 and !empty; on acceptance rptr increments.
REQ-016 The counter SHALL update per cycle as: write only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-017 tx_packet_data SHALL equal mem[rptr] whenever !empty and SHALL be 8'h00 when empty, with no added latency; a byte written in cycle N SHALL be visible no earlier than cycle N+1.
REQ-018 Simultaneous write and pop while empty SHALL accept the write only; the pop is rejected and underflow_err is set.
REQ-019 A write while full without a same-cycle pop SHALL be dropped, leaving memory, wptr and count unchanged, and SHALL set overflow_err.
REQ-020 A pop while empty SHALL leave rptr and count unchanged and SHALL set underflow_err.
REQ-021 clear=1 SHALL take priority over store and pop in the same cycle: next cycle wptr=rptr=0, count=0, both error flags are 0, and any same-cycle write or pop is discarded.
REQ-022 Memory contents SHALL NOT be cleared by clear or rst; only the pointers and count are cleared.
REQ-023 Error flags SHALL remain set until clear or rst.

Reset
REQ-024 With rst=1 at a rising edge, the next cycle SHALL have wptr=rptr=0, buffer_occupancy=0, empty=1, full=0, overflow_err=0, underflow_err=0 and tx_packet_data=8'h00.
REQ-025 rst SHALL override clear, store_tx_data and get_tx_packet_data; reset mid-transfer SHALL discard all buffered bytes.

Verification
REQ-026 The bench SHALL cover fill order: write 0x11,0x22,0x33,0x44 on consecutive cycles -> occupancy 1,2,3,4; tx_packet_data=0x11; pops return 0x11,0x22,0x33,0x44; then empty=1 and data=0x00.
REQ-027 The bench SHALL cover full and overflow: 64 writes -> full=1, occupancy=64; a 65th write of 0xAA -> dropped, overflow_err=1; 64 pops return the original sequence.
REQ-028 The bench SHALL cover simultaneous operations: at occupancy=64, write 0x55 plus pop -> occupancy stays 64, no overflow; at occupancy=0, write 0x66 plus pop -> occupancy=1, underflow_err=1, data=0x66.
REQ-029 The bench SHALL cover wrap-around: 60 writes, 60 pops, 10 writes, 10 pops -> bytes return in order across the pointer wrap, and occupancy returns to 0.
REQ-030 The bench SHALL cover clear priority: at occupancy=5, clear plus store plus pop -> occupancy=0, empty=1, error flags 0.
REQ-031 The bench SHALL cover reset mid-operation: at occupancy=7, rst=1 for one cycle -> all outputs at reset values; a subsequent write of 0x9C reads back 0x9C.
